seg_sweep_anim: RTL and testbench

- Parametrised multi-digit 7-segment animation driver. Successor to the fixed 3-digit, 1 s "loop-around" display animator.
- Moves a segment pattern around the display: the top pattern runs across the digits, then the bottom pattern runs back.
- Adds digit count, tick rate and patterns as parameters, plus run/pause, direction, a multiplexed "fill" mode and step/wrap strobes.
- Sits between the board clock and the 7-segment pins (seg, baza).

---
 rtl/seg_sweep_anim.sv | 105 ++++++++++
 tb/tb_seg_sweep_anim.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seg_sweep_anim.sv
// Multi-digit 7-segment sweep animator: a pattern runs out across the digits and
// returns on the bottom row, with sweep (single digit) or multiplexed fill display.
module seg_sweep_anim #(
    parameter int          N_DIG       = 3,
    parameter int          TICK_DIV    = 6000000,
    parameter int          REFRESH_DIV = 6000,
    parameter logic [7:0]  PAT_TOP     = 8'b00111001,
    parameter logic [7:0]  PAT_BOT     = 8'b11000101
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iRUN,
    input  logic             iDIR,
    input  logic             iMODE,
    output logic [7:0]       seg,
    output logic [N_DIG-1:0] baza,
    output logic             oStep,
    output logic             oWrap
);
    localparam int NST = 2 * N_DIG;
    localparam int SW  = $clog2(NST);
    localparam int KW  = $clog2(N_DIG);
    localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [TW-1:0]    tickCnt;
    logic [RW-1:0]    refCnt;
    logic [KW-1:0]    scanIdx;
    logic [SW-1:0]    rStan;
    logic [SW-1:0]    pos;
    logic             inTop;
    logic             tick;
    logic [7:0]       pat;
    logic [N_DIG-1:0] digOn;

    // Counter freezes while paused so a resume neither loses nor adds a step.
    assign tick = iRUN && (tickCnt == TW'(TICK_DIV - 1));

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            tickCnt <= '0;
        else if (iRUN)
            tickCnt <= tick ? '0 : tickCnt + 1'b1;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rStan <= '0;
            oStep <= 1'b0;
            oWrap <= 1'b0;
        end else begin
            oStep <= tick;
            oWrap <= 1'b0;
            if (tick) begin
                if (!iDIR) begin
                    if (rStan == SW'(NST - 1)) begin
                        rStan <= '0;
                        oWrap <= 1'b1;
                    end else begin
                        rStan <= rStan + 1'b1;
                    end
                end else begin
                    if (rStan == '0) begin
                        rStan <= SW'(NST - 1);
                        oWrap <= 1'b1;
                    end else begin
                        rStan <= rStan - 1'b1;
                    end
                end
            end
        end
    end

    // Multiplex scan keeps running regardless of iRUN so a frozen fill bar stays lit.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            refCnt  <= '0;
            scanIdx <= '0;
        end else if (refCnt == RW'(REFRESH_DIV - 1)) begin
            refCnt  <= '0;
            scanIdx <= (scanIdx == KW'(N_DIG - 1)) ? '0 : scanIdx + 1'b1;
        end else begin
            refCnt  <= refCnt + 1'b1;
        end
    end

    assign inTop = (rStan < SW'(N_DIG));
    assign pos   = inTop ? rStan : SW'(NST - 1) - rStan;
    assign pat   = inTop ? PAT_TOP : PAT_BOT;

    for (genvar gd = 0; gd < N_DIG; gd++) begin : gDig
        assign digOn[gd] = iMODE ? ((scanIdx == KW'(gd)) && (SW'(gd) <= pos))
                                 : (SW'(gd) == pos);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            seg  <= 8'h00;
            baza <= '1;
        end else begin
            seg  <= (|digOn) ? pat : 8'h00;
            baza <= ~digOn;
        end
    end
endmodule

// File: tb/tb_seg_sweep_anim.sv
// Bench for seg_sweep_anim: N_DIG=3 and N_DIG=5 instances share stimulus and are
// checked each cycle against an arithmetic model of the animation.
module tb_seg_sweep_anim;
    localparam int TD  = 4;
    localparam int RD3 = 2;
    localparam int RD5 = 3;
    localparam logic [7:0] PT = 8'b00111001;
    localparam logic [7:0] PB = 8'b11000101;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iRUN = 1'b0;
    logic       iDIR = 1'b0;
    logic       iMODE = 1'b0;
    logic [7:0] seg3, seg5;
    logic [2:0] baza3;
    logic [4:0] baza5;
    logic       step3, wrap3, step5, wrap5;

    int total = 0;
    int bad = 0;
    bit checkEn = 1'b0;

    seg_sweep_anim #(.N_DIG(3), .TICK_DIV(TD), .REFRESH_DIV(RD3)) dut3 (
        .iCLK(iCLK), .iRST(iRST), .iRUN(iRUN), .iDIR(iDIR), .iMODE(iMODE),
        .seg(seg3), .baza(baza3), .oStep(step3), .oWrap(wrap3));

    seg_sweep_anim #(.N_DIG(5), .TICK_DIV(TD), .REFRESH_DIV(RD5)) dut5 (
        .iCLK(iCLK), .iRST(iRST), .iRUN(iRUN), .iDIR(iDIR), .iMODE(iMODE),
        .seg(seg5), .baza(baza5), .oStep(step5), .oWrap(wrap5));

    always #5 iCLK = ~iCLK;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {seg, baza} for state s of an n-digit display.
    function automatic logic [15:0] expOut(input int s, input logic mode, input int k, input int n);
        int p;
        logic [7:0] b, sg, pat;
        p   = (s < n) ? s : 2*n - 1 - s;
        pat = (s < n) ? PT : PB;
        b   = 8'hFF;
        sg  = 8'h00;
        if (!mode) begin
            b[p] = 1'b0;
            sg   = pat;
        end else if (k <= p) begin
            b[k] = 1'b0;
            sg   = pat;
        end
        return {sg, b};
    endfunction

    int r = 0, t = 0, s3 = 0, s5 = 0;
    logic [15:0] e3 = {8'h00, 8'hFF};
    logic [15:0] e5 = {8'h00, 8'hFF};
    logic eStep = 1'b0, eWrap3 = 1'b0, eWrap5 = 1'b0;

    initial forever begin
        @(posedge iCLK or posedge iRST);
        if (iRST) begin
            r = 0; t = 0; s3 = 0; s5 = 0;
            e3 = {8'h00, 8'hFF}; e5 = {8'h00, 8'hFF};
            eStep = 0; eWrap3 = 0; eWrap5 = 0;
        end else begin
            bit tk;
            e3 = expOut(s3, iMODE, (t / RD3) % 3, 3);
            e5 = expOut(s5, iMODE, (t / RD5) % 5, 5);
            tk = 0;
            if (iRUN) begin
                r++;
                tk = (r % TD == 0);
            end
            eStep = tk; eWrap3 = 0; eWrap5 = 0;
            if (tk) begin
                if (!iDIR) begin
                    eWrap3 = (s3 == 5); s3 = (s3 + 1) % 6;
                    eWrap5 = (s5 == 9); s5 = (s5 + 1) % 10;
                end else begin
                    eWrap3 = (s3 == 0); s3 = (s3 + 5) % 6;
                    eWrap5 = (s5 == 0); s5 = (s5 + 9) % 10;
                end
            end
            t++;
        end
    end

    always @(negedge iCLK) begin
        if (checkEn) begin
            chk("seg3",  seg3,  e3[15:8]);
            chk("baza3", baza3, e3[2:0]);
            chk("step3", step3, eStep);
            chk("wrap3", wrap3, eWrap3);
            chk("seg5",  seg5,  e5[15:8]);
            chk("baza5", baza5, e5[4:0]);
            chk("step5", step5, eStep);
            chk("wrap5", wrap5, eWrap5);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    initial begin
        edges(2);
        iRST = 1'b0;
        iRUN = 1'b1;
        checkEn = 1'b1;
        // Hand-computed forward sweep expectations.
        edges(1);
        chk("lit_reset_state_baza", baza3, 3'b110);
        chk("lit_reset_state_seg", seg3, PT);
        edges(3);
        chk("lit_first_step", step3, 1);
        edges(1);
        chk("lit_state1_baza", baza3, 3'b101);
        edges(16);
        chk("lit_state5_baza", baza3, 3'b110);
        chk("lit_state5_seg", seg3, PB);
        chk("lit_n5_state5_baza", baza5, 5'b01111);
        edges(3);
        chk("lit_wrap3", wrap3, 1);
        chk("lit_nowrap5", wrap5, 0);
        edges(6);
        // Pause with counter at 2, resume: step exactly 2 cycles later.
        iRUN = 1'b0;
        edges(50);
        chk("lit_pause_nostep", step3, 0);
        iRUN = 1'b1;
        edges(1);
        chk("lit_resume_edge1", step3, 0);
        edges(1);
        chk("lit_resume_edge2", step3, 1);
        iMODE = 1'b1;
        edges(9);
        iDIR = 1'b1;
        edges(17);
        iMODE = 1'b0;
        edges(3);
        // Asynchronous reset mid-cycle.
        #2 iRST = 1'b1;
        #1;
        chk("lit_async_seg", seg3, 8'h00);
        chk("lit_async_baza3", baza3, 3'b111);
        chk("lit_async_baza5", baza5, 5'b11111);
        edges(1);
        iRST = 1'b0;
        iDIR = 1'b0;
        edges(4);
        chk("lit_post_reset_step", step3, 1);
        edges(1);
        chk("lit_post_reset_baza", baza3, 3'b101);
        // Randomized run/direction/mode/reset activity.
        for (int i = 0; i < 3000; i++) begin
            edges(1);
            if ($urandom_range(0, 7) == 0) iRUN = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 30) == 0) iDIR = ~iDIR;
            if ($urandom_range(0, 40) == 0) iMODE = ~iMODE;
            if ($urandom_range(0, 600) == 0) begin
                #2 iRST = 1'b1;
                edges(1);
                iRST = 1'b0;
            end
        end
        edges(1);
        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
